// File: rtl/game_pkg.sv
// Shared Duck Hunt game-logic constants (65 MHz pixel clock) and the magazine FSM state type.
package game_pkg;

  localparam int MAG_SIZE_DEF        = 3;
  localparam int COOLDOWN_CYCLES_DEF = 13_000_000;  // 0.2 s
  localparam int RELOAD_CYCLES_DEF   = 32_500_000;  // 0.5 s per round
  localparam int CNT_W_DEF           = 25;

  typedef enum logic [1:0] {IDLE, READY, COOLDOWN, RELOADING} mag_state_t;

endpackage

// File: rtl/magazine_ctrl_edge_rise.sv
// Rising-edge detector: registers the level and emits a one-cycle pulse on a 0->1 transition.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,
  output logic rise_o
);

  logic lvl_q;

  always_ff @(posedge clk) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/magazine_ctrl.sv
// Player ammunition FSM: shots, cooldown, timed one-round reloads and HUD bullet count.
// Build option: define MAGAZINE_AUTO_RELOAD_EN to start a reload automatically once the magazine empties.
module magazine_ctrl
  import game_pkg::*;
#(
  parameter int MAG_SIZE        = MAG_SIZE_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter int RELOAD_CYCLES   = RELOAD_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_enable,
  input  logic       trigger,
  input  logic       reload_req,
  output logic [2:0] bullets_in_magazine,
  output logic       shot_fired,
  output logic       dry_fire,
  output logic       reloading
);

  localparam logic [2:0]       FULL    = 3'(MAG_SIZE);
  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RL_LOAD = CNT_W'(RELOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);

  mag_state_t       state_q;
  logic [CNT_W-1:0] timer_q;
  logic [2:0]       bullets_q;
  logic             shot_q, dry_q, reloading_q;
  logic             trig_rise, rel_rise;

  edge_rise u_trig_edge (.clk(clk), .rst(rst), .lvl_i(trigger),    .rise_o(trig_rise));
  edge_rise u_rel_edge  (.clk(clk), .rst(rst), .lvl_i(reload_req), .rise_o(rel_rise));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bullets_q   <= FULL;
      shot_q      <= 1'b0;
      dry_q       <= 1'b0;
      reloading_q <= 1'b0;
    end else begin
      shot_q <= 1'b0;
      dry_q  <= 1'b0;
      if (!game_enable) begin
        // Leaving play always refills so the next round starts with a full magazine.
        state_q     <= IDLE;
        timer_q     <= '0;
        bullets_q   <= FULL;
        reloading_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            bullets_q <= FULL;
            state_q   <= READY;
          end
          READY: begin
            if (trig_rise) begin
              if (bullets_q != 3'd0) begin
                bullets_q <= bullets_q - 3'd1;
                shot_q    <= 1'b1;
                timer_q   <= CD_LOAD;
                state_q   <= COOLDOWN;
              end else begin
                dry_q <= 1'b1;
              end
            end else if (rel_rise && (bullets_q < FULL)) begin
              timer_q     <= RL_LOAD;
              reloading_q <= 1'b1;
              state_q     <= RELOADING;
            end
          end
          COOLDOWN: begin
            if (timer_q == '0) begin
`ifdef MAGAZINE_AUTO_RELOAD_EN
              if (bullets_q == 3'd0) begin
                timer_q     <= RL_LOAD;
                reloading_q <= 1'b1;
                state_q     <= RELOADING;
              end else begin
                state_q <= READY;
              end
`else
              state_q <= READY;
`endif
            end else begin
              timer_q <= timer_q - T_ONE;
            end
          end
          RELOADING: begin
            if (trig_rise && (bullets_q != 3'd0)) begin
              // Firing aborts the reload; the round in progress is simply lost.
              bullets_q   <= bullets_q - 3'd1;
              shot_q      <= 1'b1;
              timer_q     <= CD_LOAD;
              reloading_q <= 1'b0;
              state_q     <= COOLDOWN;
            end else begin
              if (trig_rise) dry_q <= 1'b1;
              if (timer_q == '0) begin
                bullets_q <= bullets_q + 3'd1;
                if ((bullets_q + 3'd1) == FULL) begin
                  reloading_q <= 1'b0;
                  state_q     <= READY;
                end else begin
                  timer_q <= RL_LOAD;
                end
              end else begin
                timer_q <= timer_q - T_ONE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bullets_in_magazine = bullets_q;
  assign shot_fired          = shot_q;
  assign dry_fire            = dry_q;
  assign reloading           = reloading_q;

endmodule

// File: tb/tb_magazine_ctrl.sv
// Self-checking bench for magazine_ctrl with a deadline-based reference model (small timing constants).
module tb_magazine_ctrl;

  localparam int M = 3;
  localparam int C = 4;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst, game_enable, trigger, reload_req;
  logic [2:0] bullets_in_magazine;
  logic       shot_fired, dry_fire, reloading;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  magazine_ctrl #(.MAG_SIZE(M), .COOLDOWN_CYCLES(C), .RELOAD_CYCLES(R), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .game_enable(game_enable), .trigger(trigger), .reload_req(reload_req),
    .bullets_in_magazine(bullets_in_magazine), .shot_fired(shot_fired),
    .dry_fire(dry_fire), .reloading(reloading)
  );

  // Reference model: absolute-cycle deadlines for cooldown end and next round insertion.
  int cyc = 0;
  bit m_play, m_shot, m_dry, m_rel, m_cool, p_trig, p_rel;
  int m_bul = M;
  int cool_end, next_ins;

  task automatic tick(input bit r, input bit en, input bit t, input bit l);
    bit tr, lr;
    rst = r; game_enable = en; trigger = t; reload_req = l;
    @(posedge clk);
    cyc++;
    tr = t && !p_trig;
    lr = l && !p_rel;
    m_shot = 0; m_dry = 0;
    if (r) begin
      m_play = 0; m_bul = M; m_cool = 0; m_rel = 0; p_trig = 0; p_rel = 0;
    end else begin
      p_trig = t; p_rel = l;
      if (!en) begin
        m_play = 0; m_bul = M; m_cool = 0; m_rel = 0;
      end else if (!m_play) begin
        m_play = 1;
      end else if (m_cool) begin
        if (cyc == cool_end) begin
          m_cool = 0;
`ifdef MAGAZINE_AUTO_RELOAD_EN
          if (m_bul == 0) begin m_rel = 1; next_ins = cyc + R; end
`endif
        end
      end else if (tr && m_bul > 0) begin
        m_bul--; m_shot = 1; m_cool = 1; cool_end = cyc + C; m_rel = 0;
      end else begin
        if (tr) m_dry = 1;
        if (m_rel) begin
          if (cyc == next_ins) begin
            m_bul++;
            if (m_bul == M) m_rel = 0;
            else next_ins = cyc + R;
          end
        end else if (!tr && lr && m_bul < M) begin
          m_rel = 1; next_ins = cyc + R;
        end
      end
    end
    #1;
  endtask

  task automatic init();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
  endtask

  task automatic shoot_and_wait();
    tick(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    tick(1, 1, 1, 1);
    tick(1, 1, 1, 1);
    total++;
    if ({bullets_in_magazine, shot_fired, dry_fire, reloading} !== {3'(M), 3'b000}) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", {bullets_in_magazine, shot_fired, dry_fire, reloading}, {3'(M), 3'b000});
    end
  endtask

  task automatic test_single_shot();
    int shots = 0;
    init();
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 1, 0);
      if (shot_fired) shots++;
    end
    tick(0, 1, 0, 0);
    total++;
    if (shots !== 1) begin bad++; $display("FAIL held_trigger_pulses got=%0d want=1", shots); end
    total++;
    if (bullets_in_magazine !== 3'd2) begin bad++; $display("FAIL held_trigger_bullets got=%0d want=2", bullets_in_magazine); end
  endtask

  task automatic test_empty_dry_fire();
    init();
    for (int k = 0; k < 4; k++) begin
      tick(0, 1, 1, 0);
      if (k < 3) begin
        total++;
        if (shot_fired !== 1'b1 || bullets_in_magazine !== 3'(2 - k)) begin
          bad++;
          $display("FAIL shot_%0d got shot=%b bul=%0d want shot=1 bul=%0d", k, shot_fired, bullets_in_magazine, 2 - k);
        end
      end else begin
        total++;
        if ({dry_fire, shot_fired, bullets_in_magazine} !== {1'b1, 1'b0, 3'd0}) begin
          bad++;
          $display("FAIL dry_fire got dry=%b shot=%b bul=%0d want dry=1 shot=0 bul=0", dry_fire, shot_fired, bullets_in_magazine);
        end
      end
      for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
    end
  endtask

  task automatic test_cooldown_discard();
    init();
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    total++;
    if (shot_fired !== 1'b0 || bullets_in_magazine !== 3'd2) begin
      bad++;
      $display("FAIL cooldown_press got shot=%b bul=%0d want shot=0 bul=2", shot_fired, bullets_in_magazine);
    end
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    total++;
    if (shot_fired !== 1'b1 || bullets_in_magazine !== 3'd1) begin
      bad++;
      $display("FAIL after_cooldown got shot=%b bul=%0d want shot=1 bul=1", shot_fired, bullets_in_magazine);
    end
    tick(0, 1, 0, 0);
  endtask

  task automatic test_reload_sequence();
    init();
    shoot_and_wait();
    shoot_and_wait();
    tick(0, 1, 1, 0);
`ifdef MAGAZINE_AUTO_RELOAD_EN
    for (int i = 1; i <= 4; i++) begin
      tick(0, 1, 0, 0);
      if (i == 3) begin
        total++;
        if (reloading !== 1'b0) begin bad++; $display("FAIL auto_reload_early got=%b want=0", reloading); end
      end
    end
`else
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
    tick(0, 1, 0, 1);
`endif
    total++;
    if (reloading !== 1'b1 || bullets_in_magazine !== 3'd0) begin
      bad++;
      $display("FAIL reload_start got rel=%b bul=%0d want rel=1 bul=0", reloading, bullets_in_magazine);
    end
    for (int i = 1; i <= 24; i++) begin
      tick(0, 1, 0, 0);
      if (i == 7 || i == 8 || i == 16 || i == 23 || i == 24) begin
        total++;
        if (bullets_in_magazine !== 3'((i - (i % 8)) / 8) || reloading !== (i != 24)) begin
          bad++;
          $display("FAIL reload_step_%0d got bul=%0d rel=%b want bul=%0d rel=%b",
                   i, bullets_in_magazine, reloading, (i - (i % 8)) / 8, i != 24);
        end
      end
    end
  endtask

  task automatic test_reload_abort();
    init();
    shoot_and_wait();
    shoot_and_wait();
    tick(0, 1, 0, 1);
    for (int i = 1; i <= 9; i++) tick(0, 1, 0, 0);
    total++;
    if (bullets_in_magazine !== 3'd2) begin bad++; $display("FAIL abort_pre got=%0d want=2", bullets_in_magazine); end
    tick(0, 1, 1, 0);
    total++;
    if ({shot_fired, reloading, bullets_in_magazine} !== {1'b1, 1'b0, 3'd1}) begin
      bad++;
      $display("FAIL abort_fire got shot=%b rel=%b bul=%0d want shot=1 rel=0 bul=1", shot_fired, reloading, bullets_in_magazine);
    end
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
    total++;
    if (reloading !== 1'b0 || bullets_in_magazine !== 3'd1) begin
      bad++;
      $display("FAIL abort_lost_round got rel=%b bul=%0d want rel=0 bul=1", reloading, bullets_in_magazine);
    end
  endtask

  task automatic test_disable_mid_reload();
    init();
    shoot_and_wait();
    shoot_and_wait();
    tick(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    total++;
    if (reloading !== 1'b0 || bullets_in_magazine !== 3'(M)) begin
      bad++;
      $display("FAIL disable_refill got rel=%b bul=%0d want rel=0 bul=%0d", reloading, bullets_in_magazine, M);
    end
    tick(0, 1, 0, 0);
  endtask

  task automatic test_random();
    bit t = 0, l = 0, r, en;
    init();
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom % 300) == 0;
      en = ($urandom % 150) != 0;
      if ($urandom % 5 == 0) t = ~t;
      if ($urandom % 9 == 0) l = ~l;
      tick(r, en, t, l);
      total++;
      if ({bullets_in_magazine, shot_fired, dry_fire, reloading} !== {3'(m_bul), m_shot, m_dry, m_rel}) begin
        bad++;
        $display("FAIL random cyc=%0d got bul/shot/dry/rel=%b want=%b", cyc,
                 {bullets_in_magazine, shot_fired, dry_fire, reloading}, {3'(m_bul), m_shot, m_dry, m_rel});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_empty_dry_fire();
    test_cooldown_discard();
    test_reload_sequence();
    test_reload_abort();
    test_disable_mid_reload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
